pc_sequencer: RTL and testbench

Fetch sequencer that owns the program counter and drives the instruction-fetch handshake for the single-cycle lab CPU. It holds the PC, requests each instruction from instruction memory, presents it to decode/execute with a valid/ready handshake, and picks the next PC: sequential, redirect, or halt. It replaces the free-running PC update path with an explicit state machine so that memory latency, execute stalls, redirects and halt are sequenced in one place.

---
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//    Fetch sequencer for the single-cycle lab CPU. Owns the program counter,
//    issues instruction-fetch requests, presents each fetched instruction to
//    decode/execute through a valid/ready handshake, and selects the next PC
//    (sequential, redirect, or halt).
//
// Ports
//    clk, reset        rising-edge clock, asynchronous active-low reset
//    start             leave IDLE/HALTED and begin fetching
//    imem_req/addr     fetch request (held until imem_ack), fetch address = pc
//    imem_ack/rdata    fetch completion and instruction word
//    instr_valid/ready instruction handshake towards decode/execute
//    instr, instr_pc   latched instruction word and its PC
//    ex_redirect/target taken branch/jump, qualified by accept
//    halt_op           accepted instruction is HALT, qualified by accept
//    pc                current program counter
//    halted            sequencer is in HALTED
//    err               sticky misaligned-redirect flag
//    retire_count      instructions accepted since reset/restart
//
// Configuration
//    PC_ALIGN_CHECK_EN  when defined, a redirect to a target with non-zero
//                       low two bits sets err and halts instead of fetching.
//                       When undefined, targets are loaded unmodified and err
//                       stays 0.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] PC_STEP      = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        halt_op,
   output logic [31:0] pc,
   output logic        halted,
   output logic        err,
   output logic [31:0] retire_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_VALID,
      S_HALTED
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic [31:0] retire_q, retire_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        err_q, err_d;
   logic        misaligned;

`ifdef PC_ALIGN_CHECK_EN
   assign misaligned = (ex_target[1:0] != 2'b00);
`else
   // Without the check no target is treated as misaligned, so err_q never
   // leaves its reset value and the redirect path loads ex_target as-is.
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      retire_d   = retire_q;
      req_d      = req_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      err_d      = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
            end
         end

         S_FETCH: begin
            if (imem_ack) begin
               state_d    = S_VALID;
               instr_d    = imem_rdata;
               instr_pc_d = pc_q;
               req_d      = 1'b0;
               valid_d    = 1'b1;
            end
         end

         S_VALID: begin
            if (instr_ready) begin
               retire_d = retire_q + 32'd1;
               valid_d  = 1'b0;
               // HALT outranks redirect; a misaligned redirect halts with pc
               // left pointing at the offending branch.
               if (halt_op || (ex_redirect && misaligned)) begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
                  if (!halt_op) begin
                     err_d = 1'b1;
                  end
               end else begin
                  state_d = S_FETCH;
                  req_d   = 1'b1;
                  pc_d    = ex_redirect ? ex_target : (pc_q + PC_STEP);
               end
            end
         end

         S_HALTED: begin
            if (start) begin
               state_d  = S_FETCH;
               pc_d     = RESET_VECTOR;
               retire_d = '0;
               halted_d = 1'b0;
               req_d    = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_VECTOR;
         instr_q    <= '0;
         instr_pc_q <= '0;
         retire_q   <= '0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         retire_q   <= retire_d;
         req_q      <= req_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
         err_q      <= err_d;
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign instr_valid  = valid_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign pc           = pc_q;
   assign halted       = halted_q;
   assign err          = err_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//    Table-driven bench for pc_sequencer. Each table row is one fetch/accept
//    transaction; fetch addresses expected from the bench's PC model are pushed
//    to a scoreboard queue when the accept is driven and popped when the DUT
//    raises imem_req. Hand-written sequences cover misaligned redirect and
//    reset during a fetch.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic        halt_op;
   logic [31:0] pc;
   logic        halted;
   logic        err;
   logic [31:0] retire_count;

   always #5 clk = ~clk;

   pc_sequencer #(
      .RESET_VECTOR(RV),
      .PC_STEP     (32'd4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .ex_redirect (ex_redirect),
      .ex_target   (ex_target),
      .halt_op     (halt_op),
      .pc          (pc),
      .halted      (halted),
      .err         (err),
      .retire_count(retire_count)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] m_retire;

   typedef struct {
      int unsigned ack_dly;
      int unsigned stall;
      logic        redir;
      logic        halt;
      logic [31:0] target;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [31:0] exp_retire;
      logic        exp_halted;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called at a negedge; the request must already be up (start/accept
   // was sampled one edge earlier). Returns the scoreboard address.
   task automatic wait_fetch(output logic [31:0] addr);
      int unsigned waited = 0;
      while (!imem_req && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("fetch_latency", 32'(waited), 32'd0);
      addr = 32'hxxxx_xxxx;
      if (exp_q.size() == 0) begin
         failures++;
         checks++;
         $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
         addr = exp_q.pop_front();
         check("imem_addr", imem_addr, addr);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_q.push_back(RV);
      m_retire = '0;
   endtask

   // One transaction: fetch (after wait_fetch), optional ack delay, valid
   // stall with noisy ignored controls, then accept.
   task automatic transact(input logic [31:0] addr, input int unsigned ack_dly,
                           input int unsigned stall, input logic redir,
                           input logic halt, input logic [31:0] target,
                           input logic [31:0] rdata, output logic halt_exp);
      logic [31:0] nxt;
      logic        mis;
      for (int unsigned i = 0; i < ack_dly; i++) begin
         imem_rdata = $urandom;
         @(negedge clk);
         check("req_held", {31'd0, imem_req}, 32'd1);
         check("addr_held", imem_addr, addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      check("valid_up", {30'd0, instr_valid, imem_req}, 32'd2);
      check("instr", instr, rdata);
      check("instr_pc", instr_pc, addr);
      for (int unsigned i = 0; i < stall; i++) begin
         instr_ready = 1'b0;
         ex_redirect = 1'b1;
         halt_op     = 1'b1;
         ex_target   = 32'hDEAD_BEE0;
         @(negedge clk);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_instr", instr, rdata);
         check("stall_pc", pc, addr);
      end
      instr_ready = 1'b1;
      ex_redirect = redir;
      halt_op     = halt;
      ex_target   = target;
`ifdef PC_ALIGN_CHECK_EN
      mis = redir && (target[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      halt_exp = halt || mis;
      m_retire = m_retire + 32'd1;
      if (!halt_exp) begin
         nxt = redir ? target : addr + 32'd4;
         exp_q.push_back(nxt);
      end
      @(negedge clk);
      instr_ready = 1'b0;
      ex_redirect = 1'b0;
      halt_op     = 1'b0;
      ex_target   = '0;
      check("retire_count", retire_count, m_retire);
      check("halted", {31'd0, halted}, {31'd0, halt_exp});
      if (halt_exp) begin
         for (int unsigned i = 0; i < 3; i++) begin
            check("halt_no_req", {31'd0, imem_req}, 32'd0);
            check("halt_pc", pc, addr);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic        h;

      //                ack stl rd hlt target          rdata           addr            ret  halted
      vecs[0] = '{0, 0, 0, 0, 32'h0,           32'h1111_0001, 32'h0000_0000, 32'd1, 1'b0};
      vecs[1] = '{0, 0, 0, 0, 32'h0,           32'h1111_0002, 32'h0000_0004, 32'd2, 1'b0};
      vecs[2] = '{0, 0, 0, 0, 32'h0,           32'h1111_0003, 32'h0000_0008, 32'd3, 1'b0};
      vecs[3] = '{0, 0, 0, 0, 32'h0,           32'h1111_0004, 32'h0000_000C, 32'd4, 1'b0};
      vecs[4] = '{3, 2, 0, 0, 32'h0,           32'h2222_0005, 32'h0000_0010, 32'd5, 1'b0};
      vecs[5] = '{0, 0, 1, 0, 32'h0000_0100,   32'h3333_0006, 32'h0000_0014, 32'd6, 1'b0};
      vecs[6] = '{0, 1, 1, 1, 32'h0000_0200,   32'h4444_0007, 32'h0000_0100, 32'd7, 1'b1};
      vecs[7] = '{0, 0, 1, 0, 32'hFFFF_FFFC,   32'h5555_0008, 32'h0000_0000, 32'd1, 1'b0};
      vecs[8] = '{0, 0, 0, 0, 32'h0,           32'h6666_0009, 32'hFFFF_FFFC, 32'd2, 1'b0};

      reset       = 1'b0;
      start       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      ex_redirect = 1'b0;
      ex_target   = '0;
      halt_op     = 1'b0;
      m_retire    = '0;

      repeat (3) @(negedge clk);
      check("rst_bits", {28'd0, imem_req, instr_valid, halted, err}, 32'd0);
      check("rst_pc", pc, RV);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_retire", retire_count, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_req", {31'd0, imem_req}, 32'd0);

      do_start();
      for (int unsigned r = 0; r < 9; r++) begin
         wait_fetch(a);
         check("tbl_addr", a, vecs[r].exp_addr);
         transact(a, vecs[r].ack_dly, vecs[r].stall, vecs[r].redir, vecs[r].halt,
                  vecs[r].target, vecs[r].rdata, h);
         check("tbl_retire", retire_count, vecs[r].exp_retire);
         check("tbl_halted", {31'd0, halted}, {31'd0, vecs[r].exp_halted});
         if (h) begin
            do_start();
            check("restart_retire", retire_count, 32'd0);
            check("restart_halted", {31'd0, halted}, 32'd0);
         end
      end

      // Misaligned redirect from address 0 (wrapped sequential fetch).
      wait_fetch(a);
      transact(a, 1, 0, 1'b1, 1'b0, 32'h0000_0102, 32'h7777_000A, h);
`ifdef PC_ALIGN_CHECK_EN
      check("mis_err", {31'd0, err}, 32'd1);
      check("mis_halted", {31'd0, halted}, 32'd1);
      do_start();
      check("mis_err_sticky", {31'd0, err}, 32'd1);
`else
      check("mis_err", {31'd0, err}, 32'd0);
`endif

      // Reset pulsed during FETCH; a late ack must not be latched.
      wait_fetch(a);
      exp_q.delete();
      #2 reset = 1'b0;
      #1;
      check("arst_req", {30'd0, imem_req, instr_valid}, 32'd0);
      check("arst_pc", pc, RV);
      check("arst_err", {31'd0, err}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_idle", {30'd0, imem_req, instr_valid}, 32'd0);
      check("post_rst_instr", instr, 32'd0);
      imem_ack = 1'b0;
      m_retire = '0;
      do_start();
      wait_fetch(a);
      transact(a, 0, 0, 1'b0, 1'b0, 32'h0, 32'h8888_000B, h);
      check("final_retire", retire_count, 32'd1);
      wait_fetch(a);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
